// File: rtl/uart_rx_param_driver.sv
// Parametrised UART receiver: synchroniser, glitch-filtered start, 3-sample majority, framing/parity/break.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_param_driver #(
    parameter int CYCLES_PER_BIT = 10,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_ODD     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] out,
    output logic                 outclk,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 brk,
    output logic                 busy
);
    localparam int HALF = CYCLES_PER_BIT / 2;
    localparam int CW   = $clog2(CYCLES_PER_BIT);
    localparam int LW   = $clog2(HALF + 1);
    localparam int BW   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           hist_q, hist_d;
    logic                 armed_q, armed_d;
    logic [LW-1:0]        low_q, low_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;
    logic                 stop0_q, stop0_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 outclk_q, outclk_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 brk_q, brk_d;

    logic       rxd_s;
    logic [2:0] win;
    logic       maj;
    logic       sample;

    assign rxd_s  = sync_q[1];
    // Vote window is the live synchronised bit plus the two before it.
    assign win    = {hist_q, rxd_s};
    assign maj    = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
    assign sample = (cyc_q == CW'(CYCLES_PER_BIT - 1));

`ifndef UART_RX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD[0];
`endif

    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[0], rxd};
        hist_d   = {hist_q[0], rxd_s};
        armed_d  = armed_q | rxd_s;
        low_d    = low_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        data_d   = data_q;
        par_d    = par_q;
        ferr_d   = ferr_q;
        stop0_d  = stop0_q;
        out_d    = out_q;
        outclk_d = 1'b0;
        fe_d     = fe_q;
        pe_d     = pe_q;
        brk_d    = 1'b0;

        if (state_q != IDLE) cyc_d = sample ? '0 : cyc_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (rxd_s)                 low_d = '0;
                else if (low_q != LW'(HALF)) low_d = low_q + 1'b1;
                if (!rxd_s && armed_q && low_q == LW'(HALF - 1)) begin
                    state_d = DATA;
                    cyc_d   = '0;
                    bit_d   = '0;
                    low_d   = '0;
                    ferr_d  = 1'b0;
                    stop0_d = 1'b1;
                    par_d   = 1'b0;
                end
            end
            DATA: if (sample) begin
                data_d = {maj, data_q[DATA_BITS-1:1]};
                bit_d  = bit_q + 1'b1;
                if (bit_q == BW'(DATA_BITS - 1)) begin
                    bit_d = '0;
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: if (sample) begin
                par_d   = maj;
                state_d = STOP;
            end
            STOP: if (sample) begin
                if (!maj) ferr_d  = 1'b1;
                else      stop0_d = 1'b0;
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(STOP_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A break needs the whole frame low, including parity and every stop sample.
                state_d = IDLE;
                cyc_d   = '0;
                if (data_q == '0 && !par_q && stop0_q) begin
                    brk_d   = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    out_d    = data_q;
                    outclk_d = 1'b1;
                    fe_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
                    pe_d     = ((^data_q) ^ par_q) != PARITY_ODD[0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            hist_q   <= 2'b11;
            armed_q  <= 1'b0;
            low_q    <= '0;
            cyc_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            ferr_q   <= 1'b0;
            stop0_q  <= 1'b0;
            out_q    <= '0;
            outclk_q <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            armed_q  <= armed_d;
            low_q    <= low_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            par_q    <= par_d;
            ferr_q   <= ferr_d;
            stop0_q  <= stop0_d;
            out_q    <= out_d;
            outclk_q <= outclk_d;
            fe_q     <= fe_d;
            pe_q     <= pe_d;
            brk_q    <= brk_d;
        end
    end

    assign out        = out_q;
    assign outclk     = outclk_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign brk        = brk_q;
    assign busy       = (state_q != IDLE);
endmodule
